// File: rtl/uart_frame_rx.sv
// Packet framer behind a byte-level UART receiver.
// Frame: SYNC, LEN, LEN payload bytes, CSUM = (LEN + sum(payload)) mod 256.
// A good frame is held in the payload buffer until the host acknowledges it.
// Errors are counted in a saturating 8-bit counter.
//
// state     | meaning
// ----------+--------------------------------------------------
// S_HUNT    | discard bytes until SYNC is seen
// S_LEN     | expect the length byte
// S_PAYLOAD | store payload bytes and accumulate the checksum
// S_CSUM    | compare the received checksum with the running sum
// S_HOLD    | good frame presented to the host until frame_ack
module uart_frame_rx #(
    parameter int          MAX_LEN     = 16,
    parameter logic [7:0]  SYNC        = 8'hA5,
    parameter int          TIMEOUT_CYC = 50_000,
    parameter int          LW          = $clog2(MAX_LEN + 1),
    parameter int          AW          = $clog2(MAX_LEN)
) (
    input  logic          clk50m,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_ready,
    input  logic          rx_error,
    output logic          frame_valid,
    output logic [LW-1:0] frame_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          frame_ack,
    output logic          busy,
    output logic [7:0]    err_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_HOLD
    } state_t;

    state_t        state, state_nx;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx;
    logic [7:0]    sum;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    buf_mem [MAX_LEN];

    logic err_inc, ld_len, wr_en, ld_frame;
    logic byte_ok, timeout_hit, busy_nx;

    // A byte coinciding with a receiver error is never accepted.
    assign byte_ok     = rx_ready & ~rx_error;
    assign timeout_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign busy_nx     = (state_nx == S_LEN) || (state_nx == S_PAYLOAD) || (state_nx == S_CSUM);

    // State register.
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) state <= S_HUNT;
        else     state <= state_nx;
    end

    // Next-state and datapath control; error abort beats byte, byte beats timeout.
    always_comb begin
        state_nx = state;
        err_inc  = 1'b0;
        ld_len   = 1'b0;
        wr_en    = 1'b0;
        ld_frame = 1'b0;
        case (state)
            S_HUNT: begin
                if (byte_ok && rx_data == SYNC) state_nx = S_LEN;
            end
            S_LEN: begin
                if (rx_error) begin
                    err_inc  = 1'b1;
                    state_nx = S_HUNT;
                end else if (rx_ready) begin
                    if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                        err_inc  = 1'b1;
                        state_nx = S_HUNT;
                    end else begin
                        ld_len   = 1'b1;
                        state_nx = S_PAYLOAD;
                    end
                end else if (timeout_hit) begin
                    err_inc  = 1'b1;
                    state_nx = S_HUNT;
                end
            end
            S_PAYLOAD: begin
                if (rx_error) begin
                    err_inc  = 1'b1;
                    state_nx = S_HUNT;
                end else if (rx_ready) begin
                    wr_en = 1'b1;
                    if (idx == len_q - 1'b1) state_nx = S_CSUM;
                end else if (timeout_hit) begin
                    err_inc  = 1'b1;
                    state_nx = S_HUNT;
                end
            end
            S_CSUM: begin
                if (rx_error) begin
                    err_inc  = 1'b1;
                    state_nx = S_HUNT;
                end else if (rx_ready) begin
                    if (rx_data == sum) begin
                        ld_frame = 1'b1;
                        state_nx = S_HOLD;
                    end else begin
                        err_inc  = 1'b1;
                        state_nx = S_HUNT;
                    end
                end else if (timeout_hit) begin
                    err_inc  = 1'b1;
                    state_nx = S_HUNT;
                end
            end
            S_HOLD: begin
                // With an ack the incoming byte is treated as a hunt byte.
                if (frame_ack) begin
                    state_nx = (byte_ok && rx_data == SYNC) ? S_LEN : S_HUNT;
                end else if (byte_ok) begin
                    err_inc = 1'b1;
                end
            end
            default: state_nx = S_HUNT;
        endcase
    end

    // Length/checksum/index tracking, held frame length, timeout and error counters.
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            len_q     <= '0;
            idx       <= '0;
            sum       <= 8'h00;
            frame_len <= '0;
            tmo_cnt   <= '0;
            err_cnt   <= 8'h00;
        end else begin
            if (ld_len) begin
                len_q <= rx_data[LW-1:0];
                sum   <= rx_data;
                idx   <= '0;
            end
            if (wr_en) begin
                sum <= sum + rx_data;
                idx <= idx + 1'b1;
            end
            if (ld_frame) frame_len <= len_q;
            if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (busy_nx && !rx_ready) tmo_cnt <= tmo_cnt + 1'b1;
            else                      tmo_cnt <= '0;
        end
    end

    // Payload storage; contents are don't-care after reset.
    always_ff @(posedge clk50m) begin
        if (wr_en) buf_mem[idx[AW-1:0]] <= rx_data;
    end

    assign frame_valid = (state == S_HOLD);
    assign busy        = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
    assign rd_data     = (frame_valid && (LW'(rd_addr) < frame_len)) ? buf_mem[rd_addr] : 8'h00;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: per-cycle vector table plus hand sequences.
module tb_uart_frame_rx;

    localparam int T = 50_000;

    logic       clk50m = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       rx_error = 1'b0;
    logic       frame_valid;
    logic [4:0] frame_len;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       frame_ack = 1'b0;
    logic       busy;
    logic [7:0] err_cnt;

    int n_vec = 0;
    int n_bad = 0;

    uart_frame_rx dut (
        .clk50m     (clk50m),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .rx_error   (rx_error),
        .frame_valid(frame_valid),
        .frame_len  (frame_len),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_ack  (frame_ack),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    always #10 clk50m = ~clk50m;

    typedef struct {
        logic       rs;
        logic       rdy;
        logic [7:0] dat;
        logic       er;
        logic       ack;
        logic [3:0] ra;
        logic       fv;
        logic [4:0] fl;
        logic       bz;
        logic [7:0] ec;
        logic [7:0] rd;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic rs, input logic rdy, input logic [7:0] dat,
                                input logic er, input logic ack, input logic [3:0] ra,
                                input logic fv, input logic [4:0] fl, input logic bz,
                                input logic [7:0] ec, input logic [7:0] rd);
        vec_t v;
        v = '{rs, rdy, dat, er, ack, ra, fv, fl, bz, ec, rd};
        vt.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(posedge clk50m);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk50m);
        #1;
    endtask

    initial begin
        //   rs rdy dat   er ack ra | fv fl  bz ec  rd
        // good frame A5 03 11 22 33 69
        add(1, 0, 8'h00, 0, 0, 0,  0, 0,  0, 0, 8'h00);
        add(0, 0, 8'h00, 0, 0, 0,  0, 0,  0, 0, 8'h00);
        add(0, 1, 8'hA5, 0, 0, 0,  0, 0,  1, 0, 8'h00);
        add(0, 1, 8'h03, 0, 0, 0,  0, 0,  1, 0, 8'h00);
        add(0, 1, 8'h11, 0, 0, 0,  0, 0,  1, 0, 8'h00);
        add(0, 1, 8'h22, 0, 0, 0,  0, 0,  1, 0, 8'h00);
        add(0, 1, 8'h33, 0, 0, 0,  0, 0,  1, 0, 8'h00);
        add(0, 1, 8'h69, 0, 0, 0,  1, 3,  0, 0, 8'h11);
        add(0, 0, 8'h00, 0, 0, 1,  1, 3,  0, 0, 8'h22);
        add(0, 0, 8'h00, 0, 0, 2,  1, 3,  0, 0, 8'h33);
        add(0, 0, 8'h00, 0, 0, 3,  1, 3,  0, 0, 8'h00);
        add(0, 0, 8'h00, 0, 1, 0,  0, 3,  0, 0, 8'h00);
        // noise, LEN=0, LEN=17, bad checksum
        add(0, 1, 8'h00, 0, 0, 0,  0, 3,  0, 0, 8'h00);
        add(0, 1, 8'hFF, 0, 0, 0,  0, 3,  0, 0, 8'h00);
        add(0, 1, 8'hA5, 0, 0, 0,  0, 3,  1, 0, 8'h00);
        add(0, 1, 8'h00, 0, 0, 0,  0, 3,  0, 1, 8'h00);
        add(0, 1, 8'hA5, 0, 0, 0,  0, 3,  1, 1, 8'h00);
        add(0, 1, 8'h11, 0, 0, 0,  0, 3,  0, 2, 8'h00);
        add(0, 1, 8'hA5, 0, 0, 0,  0, 3,  1, 2, 8'h00);
        add(0, 1, 8'h02, 0, 0, 0,  0, 3,  1, 2, 8'h00);
        add(0, 1, 8'h10, 0, 0, 0,  0, 3,  1, 2, 8'h00);
        add(0, 1, 8'h20, 0, 0, 0,  0, 3,  1, 2, 8'h00);
        add(0, 1, 8'h00, 0, 0, 0,  0, 3,  0, 3, 8'h00);
        // one-byte frame held, overrun byte, ack colliding with SYNC, new frame
        add(0, 1, 8'hA5, 0, 0, 0,  0, 3,  1, 3, 8'h00);
        add(0, 1, 8'h01, 0, 0, 0,  0, 3,  1, 3, 8'h00);
        add(0, 1, 8'h42, 0, 0, 0,  0, 3,  1, 3, 8'h00);
        add(0, 1, 8'h43, 0, 0, 0,  1, 1,  0, 3, 8'h42);
        add(0, 1, 8'h55, 0, 0, 0,  1, 1,  0, 4, 8'h42);
        add(0, 0, 8'h00, 0, 0, 1,  1, 1,  0, 4, 8'h00);
        add(0, 1, 8'hA5, 0, 1, 0,  0, 1,  1, 4, 8'h00);
        add(0, 1, 8'h01, 0, 0, 0,  0, 1,  1, 4, 8'h00);
        add(0, 1, 8'h7E, 0, 0, 0,  0, 1,  1, 4, 8'h00);
        add(0, 1, 8'h7F, 0, 0, 0,  1, 1,  0, 4, 8'h7E);
        add(0, 0, 8'h00, 0, 1, 0,  0, 1,  0, 4, 8'h00);
        add(0, 0, 8'h00, 0, 1, 0,  0, 1,  0, 4, 8'h00);

        foreach (vt[i]) begin
            rst       = vt[i].rs;
            rx_ready  = vt[i].rdy;
            rx_data   = vt[i].dat;
            rx_error  = vt[i].er;
            frame_ack = vt[i].ack;
            rd_addr   = vt[i].ra;
            @(posedge clk50m);
            #1;
            n_vec++;
            if (frame_valid !== vt[i].fv || frame_len !== vt[i].fl || busy !== vt[i].bz ||
                err_cnt !== vt[i].ec || rd_data !== vt[i].rd) begin
                n_bad++;
                $display("FAIL vec%0d: got fv=%b fl=%0d bz=%b ec=%0d rd=%h, expected fv=%b fl=%0d bz=%b ec=%0d rd=%h",
                         i, frame_valid, frame_len, busy, err_cnt, rd_data,
                         vt[i].fv, vt[i].fl, vt[i].bz, vt[i].ec, vt[i].rd);
            end
        end
        rx_ready  = 1'b0;
        frame_ack = 1'b0;
        rd_addr   = 4'd0;

        // receiver error during PAYLOAD aborts and counts
        send(8'hA5); send(8'h02); send(8'h10);
        chk("payload_busy", busy, 1);
        rx_error = 1'b1;
        idle(1);
        rx_error = 1'b0;
        chk("rxerr_busy", busy, 0);
        chk("rxerr_cnt", err_cnt, 5);
        // error wins over a simultaneous byte
        send(8'hA5);
        rx_error = 1'b1;
        send(8'h03);
        rx_error = 1'b0;
        chk("collide_busy", busy, 0);
        chk("collide_cnt", err_cnt, 6);
        // errors in HUNT are ignored
        rx_error = 1'b1;
        idle(1);
        rx_error = 1'b0;
        chk("hunt_rxerr_cnt", err_cnt, 6);

        // inter-byte timeout at exactly T clocks after the last strobe
        send(8'hA5); send(8'h02); send(8'h10);
        idle(T - 1);
        chk("tmo_busy_before", busy, 1);
        chk("tmo_cnt_before", err_cnt, 6);
        idle(1);
        chk("tmo_busy_at", busy, 0);
        chk("tmo_cnt_at", err_cnt, 7);

        // saturation
        repeat (300) begin
            send(8'hA5); send(8'h00);
        end
        chk("sat_cnt", err_cnt, 255);
        send(8'hA5); send(8'h00);
        chk("sat_hold", err_cnt, 255);

        // asynchronous reset mid-payload
        send(8'hA5); send(8'h03); send(8'h11);
        chk("pre_rst_busy", busy, 1);
        #5 rst = 1'b1;
        #1;
        chk("rst_fv", frame_valid, 0);
        chk("rst_fl", frame_len, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ec", err_cnt, 0);
        chk("rst_rd", rd_data, 0);
        @(posedge clk50m);
        #1 rst = 1'b0;
        idle(1);

        // maximum-length frame 01..10, CSUM 98
        send(8'hA5);
        send(8'h10);
        for (int b = 1; b <= 16; b++) send(8'(b));
        chk("max_busy", busy, 1);
        send(8'h98);
        chk("max_fv", frame_valid, 1);
        chk("max_fl", frame_len, 16);
        chk("max_ec", err_cnt, 0);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            chk($sformatf("max_rd%0d", a), rd_data, a + 1);
        end
        frame_ack = 1'b1;
        idle(1);
        frame_ack = 1'b0;
        chk("max_ack_fv", frame_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
